// File: rtl/gru_hidden_state_sequencer.sv
// gru_hidden_state_sequencer
//   Owns the hidden-state vector h of one GRU layer. For each timestep it
//   takes (z_t[i], n_t[i]) pairs in index order, hands each pair together
//   with h_{t-1}[i] to a single hidden-state element, writes the returned
//   h_t[i] back in place and streams it out.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_start              begin one timestep (IDLE only)
//   i_clear_state        zero all h entries (IDLE only, wins over i_start)
//   i_gate_valid/o_gate_ready, i_gate_z/i_gate_n   gate pair stream
//   o_elem_valid_in, o_elem_z/n/h_prev             request to element
//   i_elem_h_t, i_elem_valid_out                   element result
//   o_h_out_valid/data/idx/last                    h_t[i] output stream
//   o_busy, o_done, o_err_timeout                  status
//   i_rd_idx / o_rd_data                           combinational readback
module gru_hidden_state_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int HIDDEN_SIZE = 8,
  parameter int TIMEOUT     = 15,
  parameter int IDX_W       = $clog2(HIDDEN_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_clear_state,
  input  logic                  i_gate_valid,
  output logic                  o_gate_ready,
  input  logic [DATA_WIDTH-1:0] i_gate_z,
  input  logic [DATA_WIDTH-1:0] i_gate_n,
  output logic                  o_elem_valid_in,
  output logic [DATA_WIDTH-1:0] o_elem_z,
  output logic [DATA_WIDTH-1:0] o_elem_n,
  output logic [DATA_WIDTH-1:0] o_elem_h_prev,
  input  logic [DATA_WIDTH-1:0] i_elem_h_t,
  input  logic                  i_elem_valid_out,
  output logic                  o_h_out_valid,
  output logic [DATA_WIDTH-1:0] o_h_out_data,
  output logic [IDX_W-1:0]      o_h_out_idx,
  output logic                  o_h_out_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_timeout,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  // Elaboration-time sanity on the parameter set.
  if (HIDDEN_SIZE < 2) begin : g_bad_size
    $error("HIDDEN_SIZE must be >= 2");
  end
  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be < DATA_WIDTH");
  end

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [HIDDEN_SIZE];

  logic r_gate_ready, r_elem_valid_in, r_h_out_valid, r_h_out_last, r_done, r_err;
  logic [DATA_WIDTH-1:0] r_elem_z, r_elem_n, r_elem_h_prev, r_h_out_data;
  logic [IDX_W-1:0]      r_h_out_idx;

  logic w_start, w_clear, w_accept, w_wr, w_tmo, w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    w_wr        = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clear_state) begin
          w_clear = 1'b1;              // clear wins; a coincident start is dropped
        end else if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_gate_valid && r_gate_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_elem_valid_out) begin
          w_wr        = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_FETCH;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // r_cnt counts WAIT cycles already spent; this is the last allowed one
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_gate_ready    <= 1'b0;
      r_elem_valid_in <= 1'b0;
      r_elem_z        <= '0;
      r_elem_n        <= '0;
      r_elem_h_prev   <= '0;
      r_h_out_valid   <= 1'b0;
      r_h_out_data    <= '0;
      r_h_out_idx     <= '0;
      r_h_out_last    <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      for (int i = 0; i < HIDDEN_SIZE; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Strobes are registered off the next state so they line up with it.
      r_gate_ready    <= (w_state_nxt == S_FETCH);
      r_elem_valid_in <= (w_state_nxt == S_ISSUE);
      r_done          <= (w_state_nxt == S_DONE);
      r_h_out_valid   <= w_wr;

      if (w_start) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end
      if (w_accept) begin
        r_elem_z      <= i_gate_z;
        r_elem_n      <= i_gate_n;
        r_elem_h_prev <= r_mem[r_idx];
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;

      if (w_wr) begin
        r_mem[r_idx] <= i_elem_h_t;
        r_h_out_data <= i_elem_h_t;
        r_h_out_idx  <= r_idx;
        r_h_out_last <= w_last;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
      if (w_tmo) r_err <= 1'b1;
      if (w_clear) begin
        for (int i = 0; i < HIDDEN_SIZE; i++) r_mem[i] <= '0;
      end
    end
  end

  assign o_gate_ready    = r_gate_ready;
  assign o_elem_valid_in = r_elem_valid_in;
  assign o_elem_z        = r_elem_z;
  assign o_elem_n        = r_elem_n;
  assign o_elem_h_prev   = r_elem_h_prev;
  assign o_h_out_valid   = r_h_out_valid;
  assign o_h_out_data    = r_h_out_data;
  assign o_h_out_idx     = r_h_out_idx;
  assign o_h_out_last    = r_h_out_last;
  assign o_done          = r_done;
  assign o_err_timeout   = r_err;
  assign o_busy          = (r_state != S_IDLE);
  assign o_rd_data       = (int'(i_rd_idx) < HIDDEN_SIZE) ? r_mem[i_rd_idx] : '0;

endmodule

// File: doc/gru_hidden_state_sequencer.md
Name: gru_hidden_state_sequencer

Overview:
- Owns the GRU hidden-state vector h for one layer.
- Per timestep, streams (z_t, n_t) gate pairs in index order into one gru_hidden_state_element, feeding it h_{t-1}[i] from local storage.
- Collects each h_t[i] result, writes it back in place, and emits it on an output stream.
- Sits between the gate-computation stage and the hidden-state element. It is the initiator and consumer side of that element's valid_in/valid_out protocol.

Parameters:
- DATA_WIDTH, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits (informational; no arithmetic performed here).
- HIDDEN_SIZE, 8, number of hidden elements, >=2.
- TIMEOUT, 15, max cycles spent in WAIT before error.
- IDX_W, $clog2(HIDDEN_SIZE), index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one timestep (honoured in IDLE only)
- clear_state  in  1  zero all h entries (honoured in IDLE only)
- gate_valid  in  1  gate pair available
- gate_ready  out  1  sequencer accepts gate pair
- gate_z  in  DATA_WIDTH  z_t[i], signed
- gate_n  in  DATA_WIDTH  n_t[i], signed
- elem_valid_in  out  1  one-cycle request pulse to element
- elem_z  out  DATA_WIDTH  registered z to element
- elem_n  out  DATA_WIDTH  registered n to element
- elem_h_prev  out  DATA_WIDTH  registered h_{t-1}[i] to element
- elem_h_t  in  DATA_WIDTH  element result
- elem_valid_out  in  1  element result strobe
- h_out_valid  out  1  one-cycle strobe per written element
- h_out_data  out  DATA_WIDTH  h_t[i]
- h_out_idx  out  IDX_W  i
- h_out_last  out  1  high with h_out_valid when i==HIDDEN_SIZE-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last element written
- err_timeout  out  1  sticky; cleared by next accepted start
- rd_idx  in  IDX_W  readback index
- rd_data  out  DATA_WIDTH  combinational mem[rd_idx]; 0 if rd_idx>=HIDDEN_SIZE

Behaviour:
- Reset: state=IDLE, idx=0, all mem=0, all registered outputs 0 (gate_ready, elem_valid_in, elem_z/n/h_prev, h_out_*, done, err_timeout).
- States and transitions:
  - IDLE: start -> FETCH, idx=0, err_timeout=0.
  - FETCH: gate_ready=1. On gate_valid&&gate_ready, latch elem_z=gate_z, elem_n=gate_n, elem_h_prev=mem[idx] -> ISSUE.
  - ISSUE: elem_valid_in=1 for exactly this cycle; clear wait counter -> WAIT.
  - WAIT: on elem_valid_out, mem[idx]<=elem_h_t and h_out_valid=1 with data/idx/last (registered, visible the next cycle); then idx==HIDDEN_SIZE-1 -> DONE, else idx+1 -> FETCH. Otherwise the counter increments; when it reaches TIMEOUT, err_timeout=1 -> IDLE with no done pulse.
  - DONE: done=1 one cycle -> IDLE.
- Timing:
  - The element responds 2 cycles after valid_in, so WAIT lasts 2 cycles nominally.
  - Next FETCH lands on the element's return to IDLE. The sequencer never issues valid_in while the element is busy.
  - Throughput with gate_valid held high: 4 cycles/element. start to done = 4*HIDDEN_SIZE+1 cycles.
- Gate handshake: data accepted only when valid&&ready; gate_ready is 0 outside FETCH; gate_valid gaps stall in FETCH indefinitely (no timeout).
- Storage semantics:
  - In-place update; each index is read exactly once before being written within a timestep.
  - On timeout, entries 0..idx-1 hold the new h_t and entries idx.. hold h_{t-1}.
- Ignored inputs:
  - elem_valid_out outside WAIT is ignored.
  - start or clear_state while busy is ignored.
- clear_state in IDLE zeroes all mem in one cycle. If start and clear_state arrive together in IDLE, clear wins and start is dropped.
- rd_data may change mid-timestep as entries are written.
- Reset mid-operation: immediate return to IDLE, mem zeroed, all strobes low.
- No arithmetic here; h_t is stored exactly as returned.

Test Plan:
- Reset, clear_state, start, gate_valid held with z=0, n=i*256 for i=0..7 -> h_out_data=i*256, h_out_idx=i; h_out_last only at i=7; done exactly 33 cycles after start; rd_idx=5 -> rd_data=1280.
- Following timestep with z=256 (1.0), n=0x7F00 for all i -> every h_out_data equals the previous value (i*256); mem unchanged.
- h_prev=512, z=128 (0.5), n=-256 -> h_out_data=128; gate_valid low for 5 cycles between elements -> gate_ready held, no elem_valid_in issued, results still correct.
- Element stubbed to never assert valid_out -> err_timeout=1 after 15 WAIT cycles, state IDLE, no done; next start clears err_timeout.
- start and clear_state pulsed during busy -> ignored, sequence completes normally. Simultaneous start+clear_state in IDLE -> mem all 0, busy stays 0.
- rst_n asserted at idx=3 mid-WAIT -> all outputs 0 immediately, rd_data=0 for all idx; spurious elem_valid_out afterwards produces no h_out_valid.
